lsu_split: RTL and testbench

LSU_SPLIT -- requirements
Module: lsu_split

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/lsu_split.sv | 157 +++++++++++++++
 tb/tb_lsu_split.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the split-capable load/store unit.
// Holds the FSM state enum, RV32 funct3 codes and the access-size decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq1,
    StRsp1,
    StReq2,
    StRsp2,
    StDone
  } lsu_state_e;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  // Access size in bytes; unknown codes fall back to a full word.
  function automatic logic [2:0] lsu_size(input logic we, input logic [2:0] funct3);
    logic [2:0] size;
    size = 3'd4;
    if (we) begin
      if (funct3 == F3Byte) size = 3'd1;
      else if (funct3 == F3Half) size = 3'd2;
    end else begin
      if (funct3 == F3Byte || funct3 == F3ByteU) size = 3'd1;
      else if (funct3 == F3Half || funct3 == F3HalfU) size = 3'd2;
    end
    return size;
  endfunction

  function automatic logic lsu_signed(input logic [2:0] funct3);
    return (funct3 == F3Byte) || (funct3 == F3Half);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte-enable/write-data placement across up to
// two bus beats and extraction plus sign/zero extension of load results.
module lsu_lane_align #(
  parameter int unsigned BUS_W = 32,
  localparam int unsigned NB    = BUS_W / 8,
  localparam int unsigned OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0] i_off,
  input  logic [2:0]       i_size,
  input  logic             i_sext,
  input  logic [31:0]      i_wdata,
  input  logic [BUS_W-1:0] i_lo,
  input  logic [BUS_W-1:0] i_hi,
  output logic [NB-1:0]    o_be_lo,
  output logic [NB-1:0]    o_be_hi,
  output logic [BUS_W-1:0] o_wd_lo,
  output logic [BUS_W-1:0] o_wd_hi,
  output logic [31:0]      o_rdata
);

  logic [3:0]         w_size_mask;
  logic [31:0]        w_wdata_m;
  logic [2*NB-1:0]    w_mask2;
  logic [2*BUS_W-1:0] w_wd2;
  logic [31:0]        w_raw;

  always_comb begin
    w_size_mask = (i_size == 3'd1) ? 4'b0001 : (i_size == 3'd2) ? 4'b0011 : 4'b1111;
    for (int i = 0; i < 4; i++) begin
      w_wdata_m[8*i +: 8] = w_size_mask[i] ? i_wdata[8*i +: 8] : 8'h00;
    end
    // Double-width views let a boundary-crossing access be handled as one shift.
    w_mask2 = {{(2*NB-4){1'b0}}, w_size_mask} << i_off;
    w_wd2   = {{(2*BUS_W-32){1'b0}}, w_wdata_m} << {i_off, 3'b000};
    w_raw   = 32'({i_hi, i_lo} >> {i_off, 3'b000});

    o_be_lo = w_mask2[NB-1:0];
    o_be_hi = w_mask2[2*NB-1:NB];
    o_wd_lo = w_wd2[BUS_W-1:0];
    o_wd_hi = w_wd2[2*BUS_W-1:BUS_W];

    if (i_size == 3'd1) begin
      o_rdata = {{24{i_sext & w_raw[7]}}, w_raw[7:0]};
    end else if (i_size == 3'd2) begin
      o_rdata = {{16{i_sext & w_raw[15]}}, w_raw[15:0]};
    end else begin
      o_rdata = w_raw;
    end
  end

endmodule

// File: rtl/lsu_split.sv
// Memory-stage load/store unit: issues one or two aligned bus beats per access,
// splitting accesses that cross a bus-word boundary, and formats load data.
module lsu_split
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned BUS_W          = 32,
  parameter int unsigned MISALIGN_SPLIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                stall_m,
  output logic                resp_valid,
  output logic [31:0]         rdata,
  output logic                misalign_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [BUS_W/8-1:0]  bus_be,
  output logic [BUS_W-1:0]    bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [BUS_W-1:0]    bus_rdata
);

  localparam int unsigned NB    = BUS_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned SUM_W = OFF_W + 2;

  lsu_state_e        r_state, w_state_d;
  logic              r_we, r_sext, r_split, r_err;
  logic [2:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [BUS_W-1:0]  r_lo, r_hi;

  logic [2:0]        w_req_size;
  logic [SUM_W-1:0]  w_req_end;
  logic              w_req_split;
  logic [ADDR_W-1:0] w_base, w_base2;
  logic [NB-1:0]     w_be_lo, w_be_hi;
  logic [BUS_W-1:0]  w_wd_lo, w_wd_hi;
  logic [31:0]       w_rdata;

  assign w_req_size  = lsu_size(req_we, req_funct3);
  assign w_req_end   = SUM_W'(req_addr[OFF_W-1:0]) + SUM_W'(w_req_size);
  assign w_req_split = w_req_end > SUM_W'(NB);
  assign w_base      = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_base2     = w_base + ADDR_W'(NB);

  lsu_lane_align #(
    .BUS_W(BUS_W)
  ) u_lane_align (
    .i_off  (r_addr[OFF_W-1:0]),
    .i_size (r_size),
    .i_sext (r_sext),
    .i_wdata(r_wdata),
    .i_lo   (r_lo),
    .i_hi   (r_hi),
    .o_be_lo(w_be_lo),
    .o_be_hi(w_be_hi),
    .o_wd_lo(w_wd_lo),
    .o_wd_hi(w_wd_hi),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_split <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && req_valid) begin
        r_we    <= req_we;
        r_sext  <= lsu_signed(req_funct3);
        r_split <= w_req_split;
        r_err   <= (MISALIGN_SPLIT == 0) && w_req_split;
        r_size  <= w_req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == StRsp1 && bus_rvalid) r_lo <= bus_rdata;
      if (r_state == StRsp2 && bus_rvalid) r_hi <= bus_rdata;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    stall_m      = 1'b0;
    resp_valid   = 1'b0;
    rdata        = '0;
    misalign_err = 1'b0;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_be       = '0;
    bus_wdata    = '0;
    case (r_state)
      StIdle: begin
        stall_m = req_valid;
        if (req_valid) begin
          w_state_d = ((MISALIGN_SPLIT == 0) && w_req_split) ? StDone : StReq1;
        end
      end
      StReq1: begin
        stall_m   = 1'b1;
        bus_req   = 1'b1;
        bus_we    = r_we;
        bus_addr  = w_base;
        bus_be    = w_be_lo;
        bus_wdata = r_we ? w_wd_lo : '0;
        if (bus_gnt) begin
          if (!r_we) w_state_d = StRsp1;
          else       w_state_d = r_split ? StReq2 : StDone;
        end
      end
      StRsp1: begin
        stall_m = 1'b1;
        if (bus_rvalid) w_state_d = r_split ? StReq2 : StDone;
      end
      StReq2: begin
        stall_m   = 1'b1;
        bus_req   = 1'b1;
        bus_we    = r_we;
        bus_addr  = w_base2;
        bus_be    = w_be_hi;
        bus_wdata = r_we ? w_wd_hi : '0;
        if (bus_gnt) w_state_d = r_we ? StDone : StRsp2;
      end
      StRsp2: begin
        stall_m = 1'b1;
        if (bus_rvalid) w_state_d = StDone;
      end
      StDone: begin
        resp_valid   = 1'b1;
        misalign_err = r_err;
        rdata        = (r_we || r_err) ? 32'h0 : w_rdata;
        w_state_d    = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_lsu_split.sv
// Self-checking bench for lsu_split: directed scenarios plus randomized accesses
// checked against a byte-addressed memory model of the expected bus traffic.
module tb_lsu_split;

  logic        clk, rst_n;
  logic        req_valid, req_valid_ns, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall_m, resp_valid, misalign_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        stall_ns, resp_ns, err_ns, bus_req_ns, bus_we_ns;
  logic [31:0] rdata_ns, bus_addr_ns, bus_wdata_ns;
  logic [3:0]  bus_be_ns;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [bit [31:0]];

  lsu_split u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_m(stall_m), .resp_valid(resp_valid), .rdata(rdata), .misalign_err(misalign_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  lsu_split #(.MISALIGN_SPLIT(0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_ns), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_m(stall_ns), .resp_valid(resp_ns), .rdata(rdata_ns), .misalign_err(err_ns),
    .bus_req(bus_req_ns), .bus_we(bus_we_ns), .bus_addr(bus_addr_ns), .bus_be(bus_be_ns),
    .bus_wdata(bus_wdata_ns), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input bit we, input bit [2:0] f3);
    if (we) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
  endfunction

  function automatic logic [7:0] byte_at(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5a;
  endfunction

  function automatic logic [31:0] word_at(input bit [31:0] a);
    return {byte_at(a + 3), byte_at(a + 2), byte_at(a + 1), byte_at(a)};
  endfunction

  function automatic logic [31:0] m_load(input bit [2:0] f3, input bit [31:0] addr);
    int sz = m_size(1'b0, f3);
    logic [31:0] v = 0;
    for (int i = 0; i < sz; i++) v = v | (32'(byte_at(addr + i)) << (8 * i));
    if (sz == 1 && f3 == 3'b000 && v[7]) v = v | 32'hffffff00;
    if (sz == 2 && f3 == 3'b001 && v[15]) v = v | 32'hffff0000;
    return v;
  endfunction

  // One complete access; the bench plays the bus slave and checks every cycle.
  task automatic access(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, input int gdly, input int rdly,
                        output logic [31:0] o_rd, output logic [31:0] o_a1, output logic [31:0] o_a2,
                        output logic [3:0] o_be1, output logic [3:0] o_be2);
    int sz, nbeats, exp_done, n, beat, wg, wr;
    bit split, pend, done;
    bit [7:0] mask;
    bit [31:0] ea [2];
    bit [3:0] ebe [2];
    bit [31:0] ewd [2];
    bit [31:0] m32, k;
    sz = m_size(we, f3);
    split = (int'(addr[1:0]) + sz) > 4;
    nbeats = split ? 2 : 1;
    mask = 8'(((1 << sz) - 1) << addr[1:0]);
    ea[0] = addr & 32'hffff_fffc;
    ea[1] = ea[0] + 4;
    ebe[0] = mask[3:0];
    ebe[1] = mask[7:4];
    for (int b = 0; b < 2; b++) begin
      ewd[b] = 0;
      for (int l = 0; l < 4; l++) begin
        k = ea[b] + l - addr;
        if (ebe[b][l]) ewd[b][8*l +: 8] = wd[8*k +: 8];
      end
    end
    exp_done = 1 + nbeats * (1 + gdly) + (we ? 0 : nbeats * (1 + rdly));
    o_rd = 0; o_a1 = 0; o_a2 = 0; o_be1 = 0; o_be2 = 0;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0; beat = 0; wg = 0; wr = 0; pend = 0; done = 0;
    while (!done && n < 60) begin
      #1;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = $urandom;
      if (resp_valid) begin
        chk("done_cycle", n, exp_done);
        chk("beat_count", beat, nbeats);
        chk("done_stall", 32'(stall_m), 0);
        chk("done_err", 32'(misalign_err), 0);
        chk("rdata", rdata, we ? 32'h0 : m_load(f3, addr));
        o_rd = rdata;
        done = 1;
        req_valid = 0;
        if (we) for (int i = 0; i < sz; i++) mem[addr + i] = wd[8*i +: 8];
      end else begin
        chk("busy_stall", 32'(stall_m), 1);
        if (bus_req) begin
          if (beat >= nbeats) begin
            chk("extra_beat", beat, nbeats - 1);
          end else begin
            m32 = {{8{ebe[beat][3]}}, {8{ebe[beat][2]}}, {8{ebe[beat][1]}}, {8{ebe[beat][0]}}};
            chk("bus_addr", bus_addr, ea[beat]);
            chk("bus_be", 32'(bus_be), 32'(ebe[beat]));
            chk("bus_we", 32'(bus_we), 32'(we));
            if (we) chk("bus_wdata", bus_wdata & m32, ewd[beat]);
          end
          bus_rvalid = ($urandom_range(0, 3) == 0);
          if (wg < gdly) begin
            wg++;
          end else begin
            bus_gnt = 1;
            if (beat == 0) begin o_a1 = bus_addr; o_be1 = bus_be; end
            else begin o_a2 = bus_addr; o_be2 = bus_be; end
            if (!we) begin pend = 1; wr = 0; end
            beat++;
            wg = 0;
          end
        end else if (pend) begin
          if (wr < rdly) begin
            wr++;
            bus_gnt = ($urandom_range(0, 1) == 0);
          end else begin
            bus_rvalid = 1;
            bus_rdata = word_at(ea[beat - 1]);
            pend = 0;
          end
        end else begin
          bus_gnt = ($urandom_range(0, 3) == 0);
          bus_rvalid = ($urandom_range(0, 3) == 0);
        end
      end
      @(negedge clk);
      n++;
    end
    chk("timeout", 32'(done), 1);
    bus_gnt = 0; bus_rvalid = 0; req_valid = 0;
  endtask

  logic [31:0] rd, a1, a2;
  logic [3:0]  be1, be2;

  initial begin
    rst_n = 0; req_valid = 0; req_valid_ns = 0; req_we = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    @(negedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_stall", 32'(stall_m), 0);
    chk("rst_resp", 32'(resp_valid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_addr", bus_addr, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Aligned store, zero-wait bus
    access(1, 3'b010, 32'h100, 32'hdeadbeef, 0, 0, rd, a1, a2, be1, be2);
    chk("sw_addr", a1, 32'h100);
    chk("sw_be", 32'(be1), 32'hf);

    mem[32'h100] = 8'h00; mem[32'h101] = 8'h00; mem[32'h102] = 8'hff; mem[32'h103] = 8'h80;
    access(0, 3'b000, 32'h103, 0, 0, 0, rd, a1, a2, be1, be2);
    chk("lb_sext", rd, 32'hffffff80);
    access(0, 3'b100, 32'h103, 0, 0, 0, rd, a1, a2, be1, be2);
    chk("lbu_zext", rd, 32'h00000080);

    for (int i = 0; i < 8; i++) mem[32'h100 + i] = 8'(8'h11 * (i + 1));
    access(0, 3'b010, 32'h102, 0, 0, 0, rd, a1, a2, be1, be2);
    chk("lw_split_a1", a1, 32'h100);
    chk("lw_split_be1", 32'(be1), 32'hc);
    chk("lw_split_a2", a2, 32'h104);
    chk("lw_split_be2", 32'(be2), 32'h3);
    chk("lw_split_rdata", rd, 32'h66554433);
    access(1, 3'b001, 32'h0ff, 32'h0000abcd, 0, 0, rd, a1, a2, be1, be2);
    chk("sh_split_a1", a1, 32'h0fc);
    chk("sh_split_be1", 32'(be1), 32'h8);
    chk("sh_split_a2", a2, 32'h100);
    chk("sh_split_be2", 32'(be2), 32'h1);
    chk("sh_split_mem", 32'(mem[32'h100]), 32'hab);

    // Wrapping split store with a slow grant
    access(1, 3'b010, 32'hfffffffe, 32'h12345678, 3, 0, rd, a1, a2, be1, be2);
    chk("wrap_a2", a2, 32'h0);
    chk("wrap_be2", 32'(be2), 32'h3);

    // Boundary-crossing access refused when splitting is disabled
    req_valid_ns = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h102;
    #1;
    chk("ns_n_req", 32'(bus_req_ns), 0);
    chk("ns_n_stall", 32'(stall_ns), 1);
    @(negedge clk);
    #1;
    chk("ns_resp", 32'(resp_ns), 1);
    chk("ns_err", 32'(err_ns), 1);
    chk("ns_rdata", rdata_ns, 0);
    chk("ns_req", 32'(bus_req_ns), 0);
    chk("ns_stall", 32'(stall_ns), 0);
    req_valid_ns = 0;
    @(negedge clk);
    #1;
    chk("ns_after_resp", 32'(resp_ns), 0);
    chk("ns_after_err", 32'(err_ns), 0);
    @(negedge clk);

    // Reset in RSP1; a late read response must be dropped
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h108;
    @(negedge clk);
    #1;
    chk("rst_mid_req", 32'(bus_req), 1);
    bus_gnt = 1;
    @(negedge clk);
    bus_gnt = 0;
    req_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_mid_bus_req", 32'(bus_req), 0);
    chk("rst_mid_stall", 32'(stall_m), 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      bus_rvalid = 1;
      bus_rdata = 32'hcafef00d;
      #1;
      chk("late_rvalid_resp", 32'(resp_valid), 0);
      chk("late_rvalid_stall", 32'(stall_m), 0);
      @(negedge clk);
    end
    bus_rvalid = 0;
    @(negedge clk);

    for (int t = 0; t < 60; t++) begin
      bit [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? (32'hfffffff8 + $urandom_range(0, 7))
                                       : (32'h100 + $urandom_range(0, 63));
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), rd, a1, a2, be1, be2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
